// File: rtl/var_mem_pkg.sv
// Shared types and constants for the variable-assignment memory arbiter.
package var_mem_pkg;

    localparam int NREQ = 3;

    localparam logic [1:0] REQ_BCP = 2'd0;
    localparam logic [1:0] REQ_DEC = 2'd1;
    localparam logic [1:0] REQ_BT  = 2'd2;

    typedef enum logic [1:0] {
        VAL_UNASSIGNED = 2'b00,
        VAL_TRUE       = 2'b01,
        VAL_FALSE      = 2'b10
    } var_val_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_ISSUE,
        ST_RD_WAIT
    } state_t;

    function automatic logic [1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Combinational three-way round-robin pick; search starts one past last_winner.
module rr_arb3
    import var_mem_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      last_winner,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    always_comb begin
        winner = '0;
        valid  = |req;
        case (last_winner)
            REQ_BCP: begin
                if      (req[REQ_DEC]) winner = idx_to_onehot(REQ_DEC);
                else if (req[REQ_BT])  winner = idx_to_onehot(REQ_BT);
                else if (req[REQ_BCP]) winner = idx_to_onehot(REQ_BCP);
            end
            REQ_DEC: begin
                if      (req[REQ_BT])  winner = idx_to_onehot(REQ_BT);
                else if (req[REQ_BCP]) winner = idx_to_onehot(REQ_BCP);
                else if (req[REQ_DEC]) winner = idx_to_onehot(REQ_DEC);
            end
            default: begin
                if      (req[REQ_BCP]) winner = idx_to_onehot(REQ_BCP);
                else if (req[REQ_DEC]) winner = idx_to_onehot(REQ_DEC);
                else if (req[REQ_BT])  winner = idx_to_onehot(REQ_BT);
            end
        endcase
    end

endmodule

// File: rtl/var_mem_arbiter.sv
// Sequencer/arbiter for the single-port variable-assignment memory.
// state      | meaning
// ST_INIT    | clear sweep, one UNASSIGNED write per cycle, requests held off
// ST_IDLE    | waiting for init_start or a request
// ST_ISSUE   | granted access is on the memory bus this cycle
// ST_RD_WAIT | memory read data arrives; rvalid follows next cycle
module var_mem_arbiter
    import var_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          we,
    input  logic [NREQ*ADDR_W-1:0]   addr,
    input  logic [NREQ*DATA_W-1:0]   wdata,
    input  logic                     init_start,
    output logic [NREQ-1:0]          gnt,
    output logic [DATA_W-1:0]        rdata,
    output logic [NREQ-1:0]          rvalid,
    output logic                     busy,
    output logic                     init_done,
    output logic                     mem_req,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    state_t              state, next_state;
    logic [ADDR_W-1:0]   sweep_cnt, nx_cnt;
    logic                sweep_end, nx_sweep_end;
    logic [1:0]          last_winner, nx_last_winner;
    logic                cur_we, nx_cur_we;

    logic [NREQ-1:0]     nx_gnt, nx_rvalid;
    logic [DATA_W-1:0]   nx_rdata, nx_mem_wdata;
    logic [ADDR_W-1:0]   nx_mem_addr;
    logic                nx_init_done, nx_mem_req, nx_mem_rd, nx_mem_wr;

    logic [NREQ-1:0]     arb_winner;
    logic                arb_valid;
    logic [1:0]          win_idx;

    rr_arb3 u_rr_arb3 (
        .req         (req),
        .last_winner (last_winner),
        .winner      (arb_winner),
        .valid       (arb_valid)
    );

    assign win_idx = onehot_to_idx(arb_winner);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_INIT;
        else       state <= next_state;
    end

    // All bus and status outputs are registered from the next-state decision,
    // so they line up with the state they describe.
    always_comb begin
        next_state     = state;
        nx_cnt         = sweep_cnt;
        nx_sweep_end   = sweep_end;
        nx_last_winner = last_winner;
        nx_cur_we      = cur_we;
        nx_gnt         = '0;
        nx_rvalid      = '0;
        nx_rdata       = rdata;
        nx_init_done   = init_done;
        nx_mem_req     = 1'b0;
        nx_mem_rd      = 1'b0;
        nx_mem_wr      = 1'b0;
        nx_mem_addr    = mem_addr;
        nx_mem_wdata   = mem_wdata;

        case (state)
            ST_INIT: begin
                if (sweep_end) begin
                    next_state   = ST_IDLE;
                    nx_cnt       = '0;
                    nx_sweep_end = 1'b0;
                    nx_init_done = 1'b1;
                end else begin
                    nx_mem_req   = 1'b1;
                    nx_mem_wr    = 1'b1;
                    nx_mem_addr  = sweep_cnt;
                    nx_mem_wdata = DATA_W'(VAL_UNASSIGNED);
                    nx_init_done = 1'b0;
                    // Counter parks at the last address; the flag marks the sweep complete.
                    if (sweep_cnt == LAST_ADDR) nx_sweep_end = 1'b1;
                    else                        nx_cnt = sweep_cnt + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (init_start) begin
                    next_state   = ST_INIT;
                    nx_init_done = 1'b0;
                end else if (arb_valid) begin
                    next_state     = ST_ISSUE;
                    nx_gnt         = arb_winner;
                    nx_last_winner = win_idx;
                    nx_cur_we      = we[win_idx];
                    nx_mem_req     = 1'b1;
                    nx_mem_rd      = ~we[win_idx];
                    nx_mem_wr      = we[win_idx];
                    nx_mem_addr    = addr[win_idx*ADDR_W +: ADDR_W];
                    nx_mem_wdata   = wdata[win_idx*DATA_W +: DATA_W];
                end
            end
            ST_ISSUE: begin
                next_state = cur_we ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                next_state = ST_IDLE;
                nx_rdata   = mem_rdata;
                nx_rvalid  = idx_to_onehot(last_winner);
            end
            default: next_state = ST_INIT;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sweep_cnt   <= '0;
            sweep_end   <= 1'b0;
            last_winner <= REQ_BT;
            cur_we      <= 1'b0;
            gnt         <= '0;
            rvalid      <= '0;
            rdata       <= '0;
            busy        <= 1'b0;
            init_done   <= 1'b0;
            mem_req     <= 1'b0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            sweep_cnt   <= nx_cnt;
            sweep_end   <= nx_sweep_end;
            last_winner <= nx_last_winner;
            cur_we      <= nx_cur_we;
            gnt         <= nx_gnt;
            rvalid      <= nx_rvalid;
            rdata       <= nx_rdata;
            busy        <= (next_state != ST_IDLE);
            init_done   <= nx_init_done;
            mem_req     <= nx_mem_req;
            mem_rd      <= nx_mem_rd;
            mem_wr      <= nx_mem_wr;
            mem_addr    <= nx_mem_addr;
            mem_wdata   <= nx_mem_wdata;
        end
    end

endmodule

// File: tb/tb_var_mem_arbiter.sv
// Directed bench for var_mem_arbiter with ADDR_W = 3; grants and read returns
// are checked against expectation queues filled as stimulus is driven.
module tb_var_mem_arbiter;

    localparam int AW = 3;
    localparam int DW = 2;

    typedef struct {
        logic [2:0]    g;
        logic          wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } gnt_exp_t;

    typedef struct {
        logic [2:0]    rv;
        logic [DW-1:0] d;
    } rd_exp_t;

    logic              clock;
    logic              reset;
    logic [2:0]        req;
    logic [2:0]        we;
    logic [3*AW-1:0]   addr;
    logic [3*DW-1:0]   wdata;
    logic              init_start;
    logic [2:0]        gnt;
    logic [DW-1:0]     rdata;
    logic [2:0]        rvalid;
    logic              busy;
    logic              init_done;
    logic              mem_req;
    logic              mem_rd;
    logic              mem_wr;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    logic [DW-1:0]     mem_model [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    gnt_exp_t exp_gnt[$];
    rd_exp_t  exp_rd[$];
    gnt_exp_t ge;
    rd_exp_t  re;

    var_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .init_start (init_start),
        .gnt        (gnt),
        .rdata      (rdata),
        .rvalid     (rvalid),
        .busy       (busy),
        .init_done  (init_done),
        .mem_req    (mem_req),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port memory: read data valid the cycle after mem_rd.
    always @(posedge clock) begin
        if (mem_req && mem_wr) mem_model[mem_addr] <= mem_wdata;
        if (mem_req && mem_rd) mem_rdata <= mem_model[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clock) begin
        if (gnt !== 3'b000) begin
            if (exp_gnt.size() == 0) begin
                check("unexpected_gnt", 32'(gnt), 32'd0);
            end else begin
                ge = exp_gnt.pop_front();
                check("grant_bus",
                      32'({gnt, mem_req, mem_rd, mem_wr, mem_addr, (ge.wr ? mem_wdata : 2'b00)}),
                      32'({ge.g, 1'b1, ~ge.wr, ge.wr, ge.a, ge.d}));
            end
        end
        if (rvalid !== 3'b000) begin
            if (exp_rd.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'd0);
            end else begin
                re = exp_rd.pop_front();
                check("read_return", 32'({rvalid, rdata}), 32'({re.rv, re.d}));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_gnt(input logic [2:0] g, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        gnt_exp_t e;
        e.g = g; e.wr = wr; e.a = a; e.d = wr ? d : 2'b00;
        exp_gnt.push_back(e);
    endtask

    task automatic push_rd(input logic [2:0] rv, input logic [DW-1:0] d);
        rd_exp_t e;
        e.rv = rv; e.d = d;
        exp_rd.push_back(e);
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req[i]            = 1'b1;
        we[i]             = wr;
        addr[i*AW +: AW]  = a;
        wdata[i*DW +: DW] = d;
    endtask

    task automatic sweep_check(input string tag);
        for (int k = 0; k < (1 << AW); k++) begin
            tick();
            check({tag, "_write"},
                  32'({mem_req, mem_rd, mem_wr, mem_addr, mem_wdata, gnt, busy, init_done}),
                  32'({1'b1, 1'b0, 1'b1, 3'(k), 2'b00, 3'b000, 1'b1, 1'b0}));
        end
        tick();
        check({tag, "_done"}, 32'({mem_req, gnt, busy, init_done}), 32'({1'b0, 3'b000, 1'b0, 1'b1}));
    endtask

    task automatic wait_gnt_drain(input string tag, input int budget);
        int n = 0;
        while (exp_gnt.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_gnt_pending"}, 32'(exp_gnt.size()), 32'd0);
        exp_gnt.delete();
    endtask

    task automatic wait_rd_drain(input string tag, input int budget);
        int n = 0;
        while (exp_rd.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_rd_pending"}, 32'(exp_rd.size()), 32'd0);
        exp_rd.delete();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        req        = '0;
        we         = '0;
        addr       = '0;
        wdata      = '0;
        init_start = 1'b0;
        tick();
        tick();
        check("reset_state",
              32'({gnt, rvalid, busy, init_done, mem_req, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}), 32'd0);

        // Boot sweep with BCP already requesting; it must wait for init_done.
        push_gnt(3'b001, 1'b1, 3'd2, 2'b10);
        set_req(0, 1'b1, 3'd2, 2'b10);
        reset = 1'b0;
        sweep_check("boot");
        tick();
        check("boot_first_gnt", 32'(gnt), 32'(3'b001));
        req[0] = 1'b0;
        tick();

        // Single write from the decision unit.
        push_gnt(3'b010, 1'b1, 3'd5, 2'b01);
        set_req(1, 1'b1, 3'd5, 2'b01);
        tick();
        check("wr_gnt", 32'({gnt, mem_wr, mem_addr, mem_wdata, busy}),
              32'({3'b010, 1'b1, 3'd5, 2'b01, 1'b1}));
        req[1] = 1'b0;
        tick();
        check("wr_back_idle", 32'({mem_req, busy}), 32'd0);

        // Read the value just written: rvalid exactly three cycles after req.
        push_gnt(3'b001, 1'b0, 3'd5, 2'b00);
        push_rd(3'b001, 2'b01);
        set_req(0, 1'b0, 3'd5, 2'b00);
        tick();
        check("rd_gnt", 32'({gnt, mem_rd, mem_wr}), 32'({3'b001, 1'b1, 1'b0}));
        req[0] = 1'b0;
        tick();
        check("rd_wait", 32'({rvalid, mem_req, busy}), 32'({3'b000, 1'b0, 1'b1}));
        tick();
        check("rd_data", 32'({rvalid, rdata, busy}), 32'({3'b001, 2'b01, 1'b0}));

        // init_start beats a simultaneous backtrack request.
        push_gnt(3'b100, 1'b1, 3'd6, 2'b10);
        set_req(2, 1'b1, 3'd6, 2'b10);
        init_start = 1'b1;
        tick();
        check("init_accept", 32'({busy, init_done, gnt, mem_req}), 32'({1'b1, 1'b0, 3'b000, 1'b0}));
        init_start = 1'b0;
        sweep_check("reinit");
        tick();
        check("post_init_gnt", 32'(gnt), 32'(3'b100));
        req[2] = 1'b0;
        tick();

        // All three held: order 0,1,2,0,1,2; address 5 was cleared by the sweep.
        for (int r = 0; r < 2; r++) begin
            push_gnt(3'b001, 1'b1, 3'd1, 2'b01);
            push_gnt(3'b010, 1'b1, 3'd3, 2'b10);
            push_gnt(3'b100, 1'b0, 3'd5, 2'b00);
            push_rd(3'b100, 2'b00);
        end
        set_req(0, 1'b1, 3'd1, 2'b01);
        set_req(1, 1'b1, 3'd3, 2'b10);
        set_req(2, 1'b0, 3'd5, 2'b00);
        wait_gnt_drain("rr", 40);
        req = '0;
        wait_rd_drain("rr", 10);
        tick();
        tick();

        // Reset while a read sits in RD_WAIT: no rvalid, outputs clear at once.
        push_gnt(3'b001, 1'b0, 3'd3, 2'b00);
        set_req(0, 1'b0, 3'd3, 2'b00);
        tick();
        check("rst_rd_gnt", 32'(gnt), 32'(3'b001));
        req[0] = 1'b0;
        tick();
        check("rst_in_rdwait", 32'({mem_req, busy, rvalid}), 32'({1'b0, 1'b1, 3'b000}));
        #2;
        reset = 1'b1;
        #1;
        check("async_reset",
              32'({gnt, rvalid, busy, init_done, mem_req, mem_rd, mem_wr, mem_addr, mem_wdata, rdata}), 32'd0);
        tick();
        tick();
        check("reset_hold_rvalid", 32'(rvalid), 32'd0);
        reset = 1'b0;
        sweep_check("post_reset");
        tick();
        check("leftover_gnt", 32'(exp_gnt.size()), 32'd0);
        check("leftover_rd", 32'(exp_rd.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
